// File: rtl/memory_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data load/store requests.
// Data-first priority with alternation on contention, plus a per-access timeout watchdog.
module memory_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              ihit,
    output logic [DATA_W-1:0] iload,
    output logic              dhit,
    output logic [DATA_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic              ramready,
    output logic              mem_err
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DACC = 2'd1,
        IACC = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                last_instr_q, last_instr_d;
    logic                store_q, store_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                ren_q, ren_d;
    logic                wen_q, wen_d;
    logic                ihit_q, ihit_d;
    logic                dhit_q, dhit_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   iload_q, iload_d;
    logic [DATA_W-1:0]   dload_q, dload_d;

    logic d_pend;
    logic grant_data;
    logic timed_out;

    // On contention, data wins unless it was the class served last
    assign d_pend     = dREN | dWEN;
    assign grant_data = d_pend & (~iREN | last_instr_q);
    assign timed_out  = (cnt_q == CNT_W'(TIMEOUT));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_instr_q <= 1'b1;
            store_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            ren_q        <= 1'b0;
            wen_q        <= 1'b0;
            ihit_q       <= 1'b0;
            dhit_q       <= 1'b0;
            err_q        <= 1'b0;
            iload_q      <= '0;
            dload_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_instr_q <= last_instr_d;
            store_q      <= store_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            ren_q        <= ren_d;
            wen_q        <= wen_d;
            ihit_q       <= ihit_d;
            dhit_q       <= dhit_d;
            err_q        <= err_d;
            iload_q      <= iload_d;
            dload_q      <= dload_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_instr_d = last_instr_q;
        store_d      = store_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        ren_d        = 1'b0;
        wen_d        = 1'b0;
        ihit_d       = 1'b0;
        dhit_d       = 1'b0;
        err_d        = err_q;
        iload_d      = iload_q;
        dload_d      = dload_q;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (grant_data) begin
                    // A simultaneous read+write request is handled as a store
                    state_d = DACC;
                    addr_d  = daddr;
                    store_d = dWEN;
                    wdata_d = dWEN ? dstore : '0;
                    ren_d   = ~dWEN;
                    wen_d   = dWEN;
                end else if (iREN) begin
                    state_d = IACC;
                    addr_d  = iaddr;
                    store_d = 1'b0;
                    wdata_d = '0;
                    ren_d   = 1'b1;
                end
            end

            DACC, IACC: begin
                ren_d = ren_q;
                wen_d = wen_q;
                if (ramready) begin
                    state_d      = RESP;
                    ren_d        = 1'b0;
                    wen_d        = 1'b0;
                    cnt_d        = '0;
                    last_instr_d = (state_q == IACC);
                    if (state_q == IACC) begin
                        ihit_d  = 1'b1;
                        iload_d = ramload;
                    end else begin
                        dhit_d = 1'b1;
                        if (!store_q) begin
                            dload_d = ramload;
                        end
                    end
                end else if (timed_out) begin
                    // Abort: no hit, requester must re-request
                    state_d      = IDLE;
                    ren_d        = 1'b0;
                    wen_d        = 1'b0;
                    cnt_d        = '0;
                    err_d        = 1'b1;
                    last_instr_d = (state_q == IACC);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ihit     = ihit_q;
    assign dhit     = dhit_q;
    assign iload    = iload_q;
    assign dload    = dload_q;
    assign ramREN   = ren_q;
    assign ramWEN   = wen_q;
    assign ramaddr  = addr_q;
    assign ramstore = wdata_q;
    assign mem_err  = err_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: directed vector table, corner sequences,
// and random transactions checked against a transaction-level arbitration model.
module tb_memory_arbiter;

    localparam int TO = 15;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN, ramready;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic        ihit, dhit, ramREN, ramWEN, mem_err;
    logic [31:0] iload, dload, ramaddr, ramstore;

    int tests = 0;
    int fails = 0;

    // Scoreboard / model state
    bit          last_i;
    bit          me_exp;
    logic [31:0] exp_iload, exp_dload;

    memory_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .ihit(ihit), .iload(iload), .dhit(dhit), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramready(ramready), .mem_err(mem_err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit          iren, dren, dwen;
        logic [31:0] ia, da, ds;
        int          k;
        logic [31:0] rdata;
        bit          e_instr, e_store;
        logic [31:0] e_addr, e_wdata;
    } vec_t;

    vec_t tbl [7];

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk1(input string nm, input logic a, input logic e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %b, expected %b", nm, a, e);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] a, input logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, a, e);
        end
    endtask

    task automatic drop_req(input bit instr);
        if (instr) iREN = 1'b0;
        else begin
            dREN = 1'b0;
            dWEN = 1'b0;
        end
    endtask

    // Called in the IDLE cycle with requests already driven; k = wait cycles before
    // ramready (k > TO means the RAM never answers). Returns in the next IDLE cycle.
    task automatic txn(input string nm, input bit e_instr, input bit e_store,
                       input logic [31:0] e_addr, input logic [31:0] e_wdata,
                       input int k, input logic [31:0] rdata, input bit drop);
        step();
        ramready = 1'b0;
        if (drop) drop_req(e_instr);
        for (int j = 0; j <= TO; j++) begin
            chk1({nm, " ramREN"}, ramREN, !e_store);
            chk1({nm, " ramWEN"}, ramWEN, e_store);
            chk32({nm, " ramaddr"}, ramaddr, e_addr);
            if (e_store) chk32({nm, " ramstore"}, ramstore, e_wdata);
            chk1({nm, " early hit"}, ihit | dhit, 1'b0);
            if (j == k) begin
                ramready = 1'b1;
                ramload  = rdata;
            end
            step();
            ramready = 1'b0;
            if (j == k) break;
        end
        chk1({nm, " ramREN off"}, ramREN, 1'b0);
        chk1({nm, " ramWEN off"}, ramWEN, 1'b0);
        if (k <= TO) begin
            if (e_instr) exp_iload = rdata;
            else if (!e_store) exp_dload = rdata;
            chk1({nm, " ihit"}, ihit, e_instr);
            chk1({nm, " dhit"}, dhit, !e_instr);
            chk32({nm, " iload"}, iload, exp_iload);
            chk32({nm, " dload"}, dload, exp_dload);
            chk1({nm, " mem_err"}, mem_err, me_exp);
            drop_req(e_instr);
            ramready = ($urandom_range(0, 1) == 1);
            step();
            ramready = 1'b0;
            chk1({nm, " hit one cycle"}, ihit | dhit, 1'b0);
        end else begin
            me_exp = 1'b1;
            chk1({nm, " no hit on timeout"}, ihit | dhit, 1'b0);
            chk1({nm, " mem_err set"}, mem_err, 1'b1);
        end
        last_i = e_instr;
    endtask

    initial begin
        logic [1:0]  c;
        bit          gd, st;
        int          k, r;
        logic [31:0] ea;

        tbl[0] = '{1, 1, 0, 32'h40, 32'h200, 32'h0,        1,  32'h1111_0200, 0, 0, 32'h200, 32'h0};
        tbl[1] = '{1, 1, 0, 32'h40, 32'h204, 32'h0,        2,  32'h8C22_0004, 1, 0, 32'h40,  32'h0};
        tbl[2] = '{1, 1, 0, 32'h48, 32'h204, 32'h0,        0,  32'h2222_0204, 0, 0, 32'h204, 32'h0};
        tbl[3] = '{0, 0, 1, 32'h0,  32'h100, 32'hDEADBEEF, 1,  32'h5555_5555, 0, 1, 32'h100, 32'hDEADBEEF};
        tbl[4] = '{0, 1, 1, 32'h0,  32'h8,   32'h12345678, 0,  32'h6666_6666, 0, 1, 32'h8,   32'h12345678};
        tbl[5] = '{1, 0, 0, 32'h40, 32'h0,   32'h0,        0,  32'h7777_7777, 1, 0, 32'h40,  32'h0};
        tbl[6] = '{1, 0, 0, 32'h4C, 32'h0,   32'h0,        TO, 32'h8888_8888, 1, 0, 32'h4C,  32'h0};

        nRST = 1'b0;
        iREN = 0; dREN = 0; dWEN = 0; ramready = 0;
        iaddr = 0; daddr = 0; dstore = 0; ramload = 0;
        last_i = 1'b1; me_exp = 1'b0; exp_iload = '0; exp_dload = '0;
        step();
        step();
        chk1("rst ramREN", ramREN, 1'b0);
        chk1("rst ramWEN", ramWEN, 1'b0);
        chk1("rst ihit", ihit, 1'b0);
        chk1("rst dhit", dhit, 1'b0);
        chk1("rst mem_err", mem_err, 1'b0);
        chk32("rst ramaddr", ramaddr, 32'h0);
        chk32("rst ramstore", ramstore, 32'h0);
        chk32("rst iload", iload, 32'h0);
        chk32("rst dload", dload, 32'h0);
        nRST = 1'b1;

        // Directed vectors: contention order D,I,D, stores, read+write, min/max latency
        for (int i = 0; i < 7; i++) begin
            iREN = tbl[i].iren; dREN = tbl[i].dren; dWEN = tbl[i].dwen;
            iaddr = tbl[i].ia; daddr = tbl[i].da; dstore = tbl[i].ds;
            txn($sformatf("vec%0d", i), tbl[i].e_instr, tbl[i].e_store,
                tbl[i].e_addr, tbl[i].e_wdata, tbl[i].k, tbl[i].rdata, 1'b0);
        end

        // Timeout on a load, then a normal fetch with mem_err still set
        iREN = 0; dREN = 1; dWEN = 0; daddr = 32'h300;
        txn("timeout", 1'b0, 1'b0, 32'h300, 32'h0, TO + 1, 32'h0, 1'b0);
        dREN = 0; iREN = 1; iaddr = 32'h500;
        txn("post_timeout", 1'b1, 1'b0, 32'h500, 32'h0, 3, 32'hCAFE_0500, 1'b0);

        // Random traffic against the arbitration model
        for (int n = 0; n < 200; n++) begin
            if (!iREN && $urandom_range(0, 1) == 1) begin
                iREN = 1; iaddr = $urandom;
            end
            if (!(dREN || dWEN) && $urandom_range(0, 1) == 1) begin
                c = 2'($urandom_range(1, 3));
                dREN = c[0]; dWEN = c[1]; daddr = $urandom; dstore = $urandom;
            end
            if (!iREN && !dREN && !dWEN) begin
                iREN = 1; iaddr = $urandom;
            end
            ramready = ($urandom_range(0, 3) == 0);
            ramload  = $urandom;
            gd = (dREN || dWEN) && (!iREN || last_i);
            st = gd && dWEN;
            ea = gd ? daddr : iaddr;
            r  = int'($urandom_range(0, 9));
            if (r == 0) k = TO + 1;
            else if (r < 4) k = int'($urandom_range(0, TO));
            else k = int'($urandom_range(0, 2));
            txn($sformatf("rnd%0d", n), !gd, st, ea, dstore, k, $urandom,
                $urandom_range(0, 3) == 0);
        end

        // Async reset in the middle of a fetch, then re-arbitration of the held request
        dREN = 0; dWEN = 0; iREN = 1; iaddr = 32'h80; ramready = 0;
        step();
        step();
        chk1("mid ramREN", ramREN, 1'b1);
        #2 nRST = 1'b0;
        #1;
        chk1("arst ramREN", ramREN, 1'b0);
        chk32("arst ramaddr", ramaddr, 32'h0);
        chk32("arst iload", iload, 32'h0);
        chk32("arst dload", dload, 32'h0);
        chk1("arst mem_err", mem_err, 1'b0);
        chk1("arst ihit", ihit, 1'b0);
        step();
        step();
        chk1("arst held ramREN", ramREN, 1'b0);
        nRST = 1'b1;
        last_i = 1'b1; me_exp = 1'b0; exp_iload = '0; exp_dload = '0;
        txn("rearb", 1'b1, 1'b0, 32'h80, 32'h0, 1, 32'h0BAD_F00D, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
